// File: rtl/wiscv_pkg.sv
// wiscv_pkg: shared decode definitions for the wiscv pipeline.
//   - RV32 base opcode values used by the decode stage
//   - imm_type_e: immediate format selected by opcode
//   - id_ex_t: payload carried in the ID/EX pipeline register
//   - imm_type_of(): opcode -> immediate format
package wiscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd_addr;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic             rd_wr_en;
        logic             is_load;
    } id_ex_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_IMM, LOAD, JALR: t = IMM_I;
            STORE:              t = IMM_S;
            BRANCH:             t = IMM_B;
            LUI, AUIPC:         t = IMM_U;
            JAL:                t = IMM_J;
            default:            t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   instr : 32-bit instruction word
//   imm   : immediate, sign-extended to DATA_WIDTH; 0 for formats without one
module imm_gen
    import wiscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm
);

    // Select the immediate layout from the opcode and sign-extend it.
    always_comb begin
        imm = '0;
        case (imm_type_of(instr[6:0]))
            IMM_I:   imm = DATA_WIDTH'($signed(instr[31:20]));
            IMM_S:   imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25],
                                                instr[11:8], 1'b0}));
            IMM_U:   imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20],
                                                instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: wiscv instruction-decode stage.
//   IF side   : i_if_valid / o_if_ready handshake, i_if_instr, i_if_pc
//   Reg file  : o_rs1_addr / o_rs2_addr (combinational), i_rs1_data / i_rs2_data
//   Bypass    : i_ex_rd_data (result of the instruction in ID/EX), MEM and WB write ports
//   Control   : i_flush kills ID and ID/EX
//   EX side   : o_ex_valid / i_ex_ready handshake plus the registered o_ex_* payload
module decode_stage
    import wiscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_ADDR_W = REG_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_valid,
    input  logic [31:0]           i_if_instr,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    output logic                  o_if_ready,
    output logic [REG_ADDR_W-1:0] o_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rs2_addr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_ex_rd_data,
    input  logic                  i_mem_rd_wr_en,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    input  logic                  i_wb_rd_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_rd_data,
    input  logic                  i_flush,
    output logic                  o_ex_valid,
    input  logic                  i_ex_ready,
    output logic [DATA_WIDTH-1:0] o_ex_pc,
    output logic [DATA_WIDTH-1:0] o_ex_rs1_val,
    output logic [DATA_WIDTH-1:0] o_ex_rs2_val,
    output logic [DATA_WIDTH-1:0] o_ex_imm,
    output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
    output logic [6:0]            o_ex_opcode,
    output logic [2:0]            o_ex_funct3,
    output logic                  o_ex_funct7b5,
    output logic                  o_ex_rd_wr_en,
    output logic                  o_ex_is_load
);

    logic [6:0]            opcode_s;
    logic [REG_ADDR_W-1:0] rd_addr_s;
    logic [REG_ADDR_W-1:0] rs1_addr_s;
    logic [REG_ADDR_W-1:0] rs2_addr_s;
    logic                  uses_rs1_s;
    logic                  uses_rs2_s;
    logic                  writes_rd_s;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] rs1_val_s;
    logic [DATA_WIDTH-1:0] rs2_val_s;
    logic                  ex_fwd_s;
    logic                  advance_s;
    logic                  stall_s;
    logic                  accept_s;
    id_ex_t                payload_s;
    id_ex_t                ex_r;
    logic                  ex_valid_r;

    assign opcode_s   = i_if_instr[6:0];
    assign rd_addr_s  = i_if_instr[11:7];
    assign rs1_addr_s = i_if_instr[19:15];
    assign rs2_addr_s = i_if_instr[24:20];

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr (i_if_instr),
        .imm   (imm_s)
    );

    // Which register sources the instruction reads and whether it writes rd.
    always_comb begin
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        case (opcode_s)
            OP: begin
                uses_rs2_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_IMM, LOAD, JALR: writes_rd_s = 1'b1;
            STORE, BRANCH:      uses_rs2_s  = 1'b1;
            LUI, AUIPC, JAL: begin
                uses_rs1_s  = 1'b0;
                writes_rd_s = 1'b1;
            end
            default: begin
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b0;
                writes_rd_s = 1'b0;
            end
        endcase
    end

    // A load still in ID/EX has no data yet, so a dependent instruction waits one cycle.
    assign stall_s = ex_valid_r && ex_r.is_load && (ex_r.rd_addr != '0) &&
                     ((uses_rs1_s && (rs1_addr_s == ex_r.rd_addr)) ||
                      (uses_rs2_s && (rs2_addr_s == ex_r.rd_addr)));

    assign advance_s  = !ex_valid_r || i_ex_ready;
    assign o_if_ready = advance_s && !stall_s && !i_flush;
    assign accept_s   = i_if_valid && o_if_ready;

    // Loads are excluded from EX forwarding: their result only exists from MEM onward.
    assign ex_fwd_s = ex_valid_r && ex_r.rd_wr_en && !ex_r.is_load;

    // Operand resolution, youngest producer first; x0 is hard-wired to zero.
    always_comb begin
        if (rs1_addr_s == '0) begin
            rs1_val_s = '0;
        end else if (ex_fwd_s && (ex_r.rd_addr == rs1_addr_s)) begin
            rs1_val_s = i_ex_rd_data;
        end else if (i_mem_rd_wr_en && (i_mem_rd_addr == rs1_addr_s)) begin
            rs1_val_s = i_mem_rd_data;
        end else if (i_wb_rd_wr_en && (i_wb_rd_addr == rs1_addr_s)) begin
            rs1_val_s = i_wb_rd_data;
        end else begin
            rs1_val_s = i_rs1_data;
        end

        if (rs2_addr_s == '0) begin
            rs2_val_s = '0;
        end else if (ex_fwd_s && (ex_r.rd_addr == rs2_addr_s)) begin
            rs2_val_s = i_ex_rd_data;
        end else if (i_mem_rd_wr_en && (i_mem_rd_addr == rs2_addr_s)) begin
            rs2_val_s = i_mem_rd_data;
        end else if (i_wb_rd_wr_en && (i_wb_rd_addr == rs2_addr_s)) begin
            rs2_val_s = i_wb_rd_data;
        end else begin
            rs2_val_s = i_rs2_data;
        end
    end

    // Assemble the payload that enters ID/EX on an accepted instruction.
    always_comb begin
        payload_s          = '0;
        payload_s.pc       = i_if_pc;
        payload_s.rs1_val  = rs1_val_s;
        payload_s.rs2_val  = rs2_val_s;
        payload_s.imm      = imm_s;
        payload_s.rd_addr  = rd_addr_s;
        payload_s.opcode   = opcode_s;
        payload_s.funct3   = i_if_instr[14:12];
        payload_s.funct7b5 = i_if_instr[30];
        payload_s.rd_wr_en = writes_rd_s && (rd_addr_s != '0);
        payload_s.is_load  = (opcode_s == LOAD);
    end

    // ID/EX register: flush wins, then advance loads an instruction or a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_valid_r <= 1'b0;
            ex_r       <= '0;
        end else if (i_flush) begin
            ex_valid_r <= 1'b0;
        end else if (advance_s) begin
            if (accept_s) begin
                ex_valid_r <= 1'b1;
                ex_r       <= payload_s;
            end else begin
                ex_valid_r <= 1'b0;
            end
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    assign o_rs1_addr    = rs1_addr_s;
    assign o_rs2_addr    = rs2_addr_s;
    assign o_ex_valid    = ex_valid_r;
    assign o_ex_pc       = ex_r.pc;
    assign o_ex_rs1_val  = ex_r.rs1_val;
    assign o_ex_rs2_val  = ex_r.rs2_val;
    assign o_ex_imm      = ex_r.imm;
    assign o_ex_rd_addr  = ex_r.rd_addr;
    assign o_ex_opcode   = ex_r.opcode;
    assign o_ex_funct3   = ex_r.funct3;
    assign o_ex_funct7b5 = ex_r.funct7b5;
    assign o_ex_rd_wr_en = ex_r.rd_wr_en;
    assign o_ex_is_load  = ex_r.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic for decode_stage,
// checked against a behavioural model of the ID stage kept in this file.
module tb_decode_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_if_valid;
    logic [31:0] i_if_instr;
    logic [31:0] i_if_pc;
    logic        o_if_ready;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_ex_rd_data;
    logic        i_mem_rd_wr_en;
    logic [4:0]  i_mem_rd_addr;
    logic [31:0] i_mem_rd_data;
    logic        i_wb_rd_wr_en;
    logic [4:0]  i_wb_rd_addr;
    logic [31:0] i_wb_rd_data;
    logic        i_flush;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [31:0] o_ex_pc;
    logic [31:0] o_ex_rs1_val;
    logic [31:0] o_ex_rs2_val;
    logic [31:0] o_ex_imm;
    logic [4:0]  o_ex_rd_addr;
    logic [6:0]  o_ex_opcode;
    logic [2:0]  o_ex_funct3;
    logic        o_ex_funct7b5;
    logic        o_ex_rd_wr_en;
    logic        o_ex_is_load;

    decode_stage dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_valid(i_if_valid), .i_if_instr(i_if_instr), .i_if_pc(i_if_pc),
        .o_if_ready(o_if_ready),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_ex_rd_data(i_ex_rd_data),
        .i_mem_rd_wr_en(i_mem_rd_wr_en), .i_mem_rd_addr(i_mem_rd_addr),
        .i_mem_rd_data(i_mem_rd_data),
        .i_wb_rd_wr_en(i_wb_rd_wr_en), .i_wb_rd_addr(i_wb_rd_addr),
        .i_wb_rd_data(i_wb_rd_data),
        .i_flush(i_flush),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_pc(o_ex_pc), .o_ex_rs1_val(o_ex_rs1_val), .o_ex_rs2_val(o_ex_rs2_val),
        .o_ex_imm(o_ex_imm), .o_ex_rd_addr(o_ex_rd_addr), .o_ex_opcode(o_ex_opcode),
        .o_ex_funct3(o_ex_funct3), .o_ex_funct7b5(o_ex_funct7b5),
        .o_ex_rd_wr_en(o_ex_rd_wr_en), .o_ex_is_load(o_ex_is_load)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the ID/EX register contents.
    logic        m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7, m_wr, m_ld;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = int'(ins >> 20);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                v = int'(((ins >> 25) << 5) | ((ins >> 7) & 32'd31));
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                v = int'((((ins >> 31) & 32'd1) << 12) | (((ins >> 7) & 32'd1) << 11) |
                         (((ins >> 25) & 32'd63) << 5) | (((ins >> 8) & 32'd15) << 1));
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: return ins & 32'hFFFFF000;
            7'h6F: begin
                v = int'((((ins >> 31) & 32'd1) << 20) | (((ins >> 12) & 32'd255) << 12) |
                         (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'd1023) << 1));
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit reads_rs1(input logic [6:0] opc);
        return !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] opc);
        return (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    endfunction

    function automatic bit has_rd(input logic [6:0] opc);
        return (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h37 ||
                opc == 7'h17 || opc == 7'h6F || opc == 7'h67);
    endfunction

    // Value the register would hold once every in-flight producer has written it.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (m_valid && m_wr && !m_ld && m_rd == a) return i_ex_rd_data;
        if (i_mem_rd_wr_en && i_mem_rd_addr == a) return i_mem_rd_data;
        if (i_wb_rd_wr_en && i_wb_rd_addr == a) return i_wb_rd_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0;
        m_rd = 5'd0; m_opc = 7'd0; m_f3 = 3'd0; m_f7 = 1'b0; m_wr = 1'b0; m_ld = 1'b0;
    endtask

    task automatic check_regs();
        check_val("ex_valid", 64'(o_ex_valid), 64'(m_valid));
        check_val("ex_pc", 64'(o_ex_pc), 64'(m_pc));
        check_val("ex_rs1_val", 64'(o_ex_rs1_val), 64'(m_rs1));
        check_val("ex_rs2_val", 64'(o_ex_rs2_val), 64'(m_rs2));
        check_val("ex_imm", 64'(o_ex_imm), 64'(m_imm));
        check_val("ex_rd_addr", 64'(o_ex_rd_addr), 64'(m_rd));
        check_val("ex_opcode", 64'(o_ex_opcode), 64'(m_opc));
        check_val("ex_funct3", 64'(o_ex_funct3), 64'(m_f3));
        check_val("ex_funct7b5", 64'(o_ex_funct7b5), 64'(m_f7));
        check_val("ex_rd_wr_en", 64'(o_ex_rd_wr_en), 64'(m_wr));
        check_val("ex_is_load", 64'(o_ex_is_load), 64'(m_ld));
    endtask

    // One clock: called at posedge+1 with inputs already driven.
    task automatic step();
        logic [4:0]  a1, a2;
        logic [6:0]  opc;
        bit          hazard, adv, rdy;
        logic [31:0] n_rs1, n_rs2;
        #4;
        opc = i_if_instr[6:0];
        a1  = i_if_instr[19:15];
        a2  = i_if_instr[24:20];
        hazard = m_valid && m_ld && m_rd != 5'd0 &&
                 ((reads_rs1(opc) && a1 == m_rd) || (reads_rs2(opc) && a2 == m_rd));
        adv = !m_valid || i_ex_ready;
        rdy = adv && !hazard && !i_flush;
        check_val("if_ready", 64'(o_if_ready), 64'(rdy));
        check_val("rs1_addr", 64'(o_rs1_addr), 64'(a1));
        check_val("rs2_addr", 64'(o_rs2_addr), 64'(a2));
        n_rs1 = operand(a1, i_rs1_data);
        n_rs2 = operand(a2, i_rs2_data);
        @(posedge i_clk);
        #1;
        if (i_flush) begin
            m_valid = 1'b0;
        end else if (adv) begin
            if (i_if_valid && rdy) begin
                m_valid = 1'b1;
                m_pc  = i_if_pc;
                m_rs1 = n_rs1;
                m_rs2 = n_rs2;
                m_imm = model_imm(i_if_instr);
                m_rd  = i_if_instr[11:7];
                m_opc = opc;
                m_f3  = i_if_instr[14:12];
                m_f7  = i_if_instr[30];
                m_wr  = has_rd(opc) && (i_if_instr[11:7] != 5'd0);
                m_ld  = (opc == 7'h03);
            end else begin
                m_valid = 1'b0;
            end
        end
        check_regs();
    endtask

    task automatic drive_idle();
        i_if_valid = 1'b0; i_if_instr = 32'h00000013; i_if_pc = 32'd0;
        i_rs1_data = $urandom; i_rs2_data = $urandom; i_ex_rd_data = $urandom;
        i_mem_rd_wr_en = 1'b0; i_mem_rd_addr = 5'd0; i_mem_rd_data = $urandom;
        i_wb_rd_wr_en = 1'b0; i_wb_rd_addr = 5'd0; i_wb_rd_data = $urandom;
        i_flush = 1'b0; i_ex_ready = 1'b1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        drive_idle();
        i_if_valid = 1'b1; i_if_instr = ins; i_if_pc = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs [10];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
        ins = $urandom;
        ins[6:0]   = opcs[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        drive_idle();
        model_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_regs();

        // Reset state: ready with nothing in flight.
        #4;
        check_val("rst_if_ready", 64'(o_if_ready), 64'd1);
        @(posedge i_clk);
        #1;

        // ADDI x1,x0,5
        issue(32'h00500093, 32'h100);
        step();
        check_val("addi_valid", 64'(o_ex_valid), 64'd1);
        check_val("addi_imm", 64'(o_ex_imm), 64'd5);
        check_val("addi_rd", 64'(o_ex_rd_addr), 64'd1);
        check_val("addi_wr", 64'(o_ex_rd_wr_en), 64'd1);
        check_val("addi_rs1", 64'(o_ex_rs1_val), 64'd0);

        // ADD x3,x1,x2 with EX/MEM both producing x1 and WB producing x2
        issue(32'h002081B3, 32'h104);
        i_ex_rd_data = 32'hA;
        i_mem_rd_wr_en = 1'b1; i_mem_rd_addr = 5'd1; i_mem_rd_data = 32'hB;
        i_wb_rd_wr_en  = 1'b1; i_wb_rd_addr  = 5'd2; i_wb_rd_data  = 32'hC;
        step();
        check_val("byp_rs1", 64'(o_ex_rs1_val), 64'hA);
        check_val("byp_rs2", 64'(o_ex_rs2_val), 64'hC);

        // LW x5,0(x1) followed by dependent ADD x6,x5,x5
        issue(32'h0000A283, 32'h108);
        step();
        issue(32'h00528333, 32'h10C);
        #4;
        check_val("lu_ready", 64'(o_if_ready), 64'd0);
        #1;
        @(posedge i_clk);
        #1;
        check_val("lu_bubble", 64'(o_ex_valid), 64'd0);
        m_valid = 1'b0;
        issue(32'h00528333, 32'h10C);
        i_mem_rd_wr_en = 1'b1; i_mem_rd_addr = 5'd5; i_mem_rd_data = 32'h1234;
        step();
        check_val("lu_valid", 64'(o_ex_valid), 64'd1);
        check_val("lu_rs1", 64'(o_ex_rs1_val), 64'h1234);
        check_val("lu_rs2", 64'(o_ex_rs2_val), 64'h1234);

        // Back-pressure: 3 cycles held, released on the 4th
        for (int k = 0; k < 3; k++) begin
            issue(32'h00100113, 32'h200);
            i_ex_ready = 1'b0;
            step();
            check_val("bp_hold_pc", 64'(o_ex_pc), 64'h10C);
            check_val("bp_hold_valid", 64'(o_ex_valid), 64'd1);
        end
        issue(32'h00100113, 32'h200);
        step();
        check_val("bp_release_pc", 64'(o_ex_pc), 64'h200);

        // Flush while a load-use stall is pending
        issue(32'h0000A283, 32'h300);
        step();
        issue(32'h00528333, 32'h304);
        i_flush = 1'b1;
        step();
        check_val("flush_valid", 64'(o_ex_valid), 64'd0);

        // Immediate formats
        issue(32'hFE000CE3, 32'h400); step();
        check_val("imm_beq", 64'(o_ex_imm), 64'hFFFFFFF8);
        issue(32'h0010006F, 32'h404); step();
        check_val("imm_jal", 64'(o_ex_imm), 64'h00000800);
        issue(32'h123450B7, 32'h408); step();
        check_val("imm_lui", 64'(o_ex_imm), 64'h12345000);
        issue(32'hFE000FA3, 32'h40C); step();
        check_val("imm_sw", 64'(o_ex_imm), 64'hFFFFFFFF);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                i_flush = 1'b0;
                i_rst = 1'b1;
                #1;
                model_reset();
                check_regs();
                check_val("rst_mid_ready", 64'(o_if_ready), 64'd1);
                @(posedge i_clk);
                #1;
                i_rst = 1'b0;
            end
            i_if_valid     = ($urandom_range(0, 9) < 8);
            i_if_instr     = rand_instr();
            i_if_pc        = $urandom;
            i_rs1_data     = $urandom;
            i_rs2_data     = $urandom;
            i_ex_rd_data   = $urandom;
            i_mem_rd_wr_en = 1'($urandom_range(0, 1));
            i_mem_rd_addr  = 5'($urandom_range(0, 3));
            i_mem_rd_data  = $urandom;
            i_wb_rd_wr_en  = 1'($urandom_range(0, 1));
            i_wb_rd_addr   = 5'($urandom_range(0, 3));
            i_wb_rd_data   = $urandom;
            i_flush        = ($urandom_range(0, 15) == 0);
            i_ex_ready     = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
